// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with a valid/ready handshake and a 2-entry
// (main + skid) buffer. in_ready and out_valid are decoded from the state
// register only, so there is no combinational path from out_ready to in_ready.
// The stage also provides a synchronous flush and a saturating stall counter.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | nothing held, main = BUBBLE_VAL, occupancy 0
//   ST_BUSY  | main holds a beat, skid empty, occupancy 1
//   ST_FULL  | main and skid both hold beats, occupancy 2
module pipe_skid_reg #(
  parameter int                DATA_W     = 96,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic in_fire;
  logic out_fire;
  logic stalled;

  // Handshake qualifiers are built from state, never from the output ports,
  // so the ready path stays purely registered.
  assign in_fire  = in_valid && (state_q != ST_FULL);
  assign out_fire = (state_q != ST_EMPTY) && out_ready;
  assign stalled  = (state_q != ST_EMPTY) && !out_ready;

  // State, payload and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE_VAL;
      skid_q      <= BUBBLE_VAL;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state and payload movement; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = ST_FULL;
        end else if (out_fire) begin
          main_d  = BUBBLE_VAL;
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          skid_d  = BUBBLE_VAL;
          state_d = ST_BUSY;
        end
      end
      default: begin
        main_d  = BUBBLE_VAL;
        skid_d  = BUBBLE_VAL;
        state_d = ST_EMPTY;
      end
    endcase
    if (flush) begin
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
      state_d = ST_EMPTY;
    end
  end

  // Stall counter sticks at all-ones instead of wrapping; a flush cycle is not a stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stalled && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Port decode from the registered state.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    in_ready  = (state_q != ST_FULL);
    out_data  = main_q;
    stall_cnt = stall_cnt_q;
    unique case (state_q)
      ST_BUSY:  occupancy = 2'd1;
      ST_FULL:  occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and random checks of pipe_skid_reg against a queue model.
module tb_pipe_skid_reg;

  localparam int DW = 96;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  logic       s_flush;
  logic       s_in_valid;
  logic       s_in_ready;
  logic [7:0] s_in_data;
  logic       s_out_valid;
  logic       s_out_ready;
  logic [7:0] s_out_data;
  logic [1:0] s_occ;
  logic [1:0] s_stall;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] exp_q[$];
  logic [15:0]   stall_exp;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(DW), .BUBBLE_VAL('0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_skid_reg #(.DATA_W(8), .BUBBLE_VAL(8'h00), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occ), .stall_cnt(s_stall)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic check_model(input string tag);
    logic [DW-1:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check({tag, ".out_valid"}, 128'(out_valid), 128'(exp_q.size() != 0));
    check({tag, ".in_ready"},  128'(in_ready),  128'(exp_q.size() < 2));
    check({tag, ".occupancy"}, 128'(occupancy), 128'(exp_q.size()));
    check({tag, ".out_data"},  128'(out_data),  128'(head));
    check({tag, ".stall_cnt"}, 128'(stall_cnt), 128'(stall_exp));
  endtask

  // One clock: model sees the pre-edge inputs, then outputs are checked #1 after the edge.
  task automatic tick(input string tag);
    bit m_valid, m_ready, m_in_fire, m_out_fire;
    m_valid    = (exp_q.size() != 0);
    m_ready    = (exp_q.size() < 2);
    m_in_fire  = in_valid && m_ready;
    m_out_fire = m_valid && out_ready;
    if (m_valid && !out_ready && !flush && stall_exp != 16'hFFFF) stall_exp++;
    @(posedge clk);
    if (m_out_fire) void'(exp_q.pop_front());
    if (flush) exp_q.delete();
    else if (m_in_fire) exp_q.push_back(in_data);
    #1;
    check_model(tag);
  endtask

  initial begin
    int sat_exp[6];
    sat_exp = '{1, 2, 3, 3, 3, 3};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 'x; out_ready = 1'b0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h00; s_out_ready = 1'b0;
    stall_exp = '0;
    #12;
    check_model("reset");
    @(negedge clk); rst_n = 1'b1;

    // 1: streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      tick("stream");
      check("stream.data_direct", 128'(out_data), 128'(i));
    end
    in_valid = 1'b0; in_data = 'x;
    tick("stream_drain");

    // 2: backpressure into the skid entry
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = DW'('hA);
    tick("bp_a");
    in_data = DW'('hB);
    tick("bp_b");
    check("bp.full_occ", 128'(occupancy), 128'(2));
    check("bp.full_ready", 128'(in_ready), 128'(0));
    in_valid = 1'b0; in_data = 'x;
    for (int i = 0; i < 3; i++) tick("bp_hold");
    check("bp.stall4", 128'(stall_cnt), 128'(4));
    out_ready = 1'b1;
    tick("bp_pop_a");
    check("bp.data_b", 128'(out_data), 128'('hB));
    tick("bp_pop_b");
    check("bp.empty_data", 128'(out_data), 128'(0));
    check("bp.stall_hold", 128'(stall_cnt), 128'(4));

    // 3: flush in FULL with a new beat offered
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = DW'('h11); tick("fl_fill1");
    in_data = DW'('h22); tick("fl_fill2");
    flush = 1'b1; in_data = DW'('hC);
    tick("fl_flush");
    flush = 1'b0; in_valid = 1'b0; in_data = 'x;
    check("fl.out_valid", 128'(out_valid), 128'(0));
    check("fl.out_data", 128'(out_data), 128'(0));
    out_ready = 1'b1;
    tick("fl_after");

    // flush in BUSY with a simultaneous input fire and output fire
    in_valid = 1'b1; in_data = DW'('h33); tick("fl2_load");
    flush = 1'b1; in_data = DW'('h44); tick("fl2_flush");
    flush = 1'b0; in_valid = 1'b0; in_data = 'x;
    tick("fl2_after");

    // 4: asynchronous reset while FULL
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = DW'('h55); tick("rst_fill1");
    in_data = DW'('h66); tick("rst_fill2");
    in_valid = 1'b0; in_data = 'x;
    tick("rst_stall");
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete(); stall_exp = '0;
    check("arst.out_valid", 128'(out_valid), 128'(0));
    check("arst.in_ready", 128'(in_ready), 128'(1));
    check("arst.occupancy", 128'(occupancy), 128'(0));
    check("arst.stall_cnt", 128'(stall_cnt), 128'(0));
    check("arst.out_data", 128'(out_data), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = DW'('h77);
    tick("rst_first_accept");
    check("arst.first_accept", 128'(out_data), 128'('h77));
    in_valid = 1'b0; in_data = 'x;
    tick("rst_drain");

    // 5: saturating stall counter on the CNT_W=2 instance
    s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 8'h5A;
    tick("sat_load");
    s_in_valid = 1'b0;
    check("sat.valid", 128'(s_out_valid), 128'(1));
    check("sat.cnt0", 128'(s_stall), 128'(0));
    for (int i = 0; i < 6; i++) begin
      tick("sat_idle");
      check($sformatf("sat.cnt%0d", i + 1), 128'(s_stall), 128'(sat_exp[i]));
    end
    check("sat.data", 128'(s_out_data), 128'(8'h5A));

    // 6: random valid/ready/flush traffic against the queue model
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 63) == 0);
      if (in_valid) in_data = {$urandom, $urandom, $urandom};
      else          in_data = 'x;
      tick("rand");
    end
    flush = 1'b0; in_valid = 1'b0; in_data = 'x; out_ready = 1'b1;
    tick("rand_drain1");
    tick("rand_drain2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised pipeline-stage register with a valid/ready handshake. It succeeds the fixed-field stage latches with en-only stall control.
- A 2-entry skid buffer (main + skid) supports full throughput. in_ready is driven only from registers, which breaks the combinational ready path between stages.
- Supports synchronous flush with bubble insertion and provides a saturating stall-cycle counter for performance monitoring.
- Instantiated between any two pipeline stages (IF/ID, ID/EX, ...), with DATA_W set to the concatenated field width (e.g. instr + pc4 + pc8 = 96).

Parameters:
DATA_W, 96, width of the payload carried through the stage
BUBBLE_VAL, 0, payload value presented when no valid beat is held (NOP encoding)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held and incoming beats
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat (registered)
in_data  input  DATA_W  upstream payload
out_valid  output  1  downstream beat valid
out_ready  input  1  downstream accepts beat
out_data  output  DATA_W  downstream payload (main register)
occupancy  output  2  beats held: 0, 1 or 2
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - A beat transfers only on fire. Data and valid must be stable; no combinational path from out_ready to in_ready.
- State machine: EMPTY (occupancy 0), BUSY (main valid, skid empty; occupancy 1), FULL (main + skid valid; occupancy 2).
- Registered outputs are decoded from state: out_valid = (state != EMPTY); in_ready = (state != FULL).
- Transitions when flush=0:
  - EMPTY:
    - in_fire -> main <= in_data, go to BUSY.
    - Otherwise stay; main holds BUBBLE_VAL.
  - BUSY:
    - in_fire & out_fire -> main <= in_data, stay in BUSY.
    - in_fire & !out_fire -> skid <= in_data, go to FULL.
    - !in_fire & out_fire -> main <= BUBBLE_VAL, go to EMPTY.
    - Neither -> hold.
  - FULL (in_ready=0, no in_fire possible):
    - out_fire -> main <= skid, skid <= BUBBLE_VAL, go to BUSY.
    - Otherwise hold.
- Latency and throughput:
  - Latency is 1 cycle: a beat accepted at edge N is on out_data/out_valid after edge N.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
- Ordering: strict FIFO; the skid entry is never presented before main.
- flush=1 (synchronous, highest priority):
  - Next state is EMPTY; main and skid are set to BUBBLE_VAL.
  - A beat that fires on the input in the same cycle is discarded.
  - A beat that fires on the output in the same cycle counts as delivered.
  - stall_cnt is unaffected.
- stall_cnt:
  - Increments by 1 on each edge where out_valid=1 & out_ready=0 & flush=0.
  - Saturates at 2^CNT_W-1; no wrap.
- out_data equals BUBBLE_VAL whenever out_valid=0.
- Reset (rst_n=0, asynchronous, any time including mid-transfer):
  - state=EMPTY, main=skid=BUBBLE_VAL, out_valid=0, in_ready=1, occupancy=0, stall_cnt=0.
  - Held beats are lost.
  - Deassertion is synchronous to clk externally; the first accept is possible on the first edge after release.
- X on in_data when in_valid=0 must not propagate into held state.

Test Plan:
1. Streaming: out_ready=1, in_valid=1 with in_data=1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, occupancy=1, in_ready stays 1, stall_cnt=0.
2. Backpressure/skid: in BUSY holding 0xA, drive out_ready=0 and in 0xB -> FULL, in_ready=0, occupancy=2. Hold out_ready=0 for 3 cycles -> stall_cnt increments by 1 per stalled edge. Then out_ready=1 -> out_data 0xA then 0xB, then EMPTY, out_data=BUBBLE_VAL.
3. Flush in FULL with simultaneous in_valid and new data 0xC -> next cycle EMPTY, out_valid=0, out_data=0, 0xC never appears on out_data.
4. Async reset mid-FULL: drop rst_n between edges -> out_valid=0, in_ready=1, occupancy=0, stall_cnt=0 immediately, without waiting for a clock edge.
5. Saturation: CNT_W=2, hold out_valid=1 & out_ready=0 for 6 cycles -> stall_cnt reads 1,2,3,3,3,3.
6. Random valid/ready toggling over 10k cycles against a reference queue model -> identical ordered output sequence, no loss or duplication, occupancy ≤ 2 always.
